// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: instruction width and the NOP encoding
// that idle pipeline stages present downstream.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH entries of {pc, instr},
// one synchronous write port and one asynchronous read port.
// Storage carries no reset; validity is tracked by the control logic.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               we,
    input  logic [AW-1:0]      waddr,
    input  logic [2*WIDTH-1:0] wdata,
    input  logic [AW-1:0]      raddr,
    output logic [2*WIDTH-1:0] rdata
);

    logic [2*WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry when the control side commits a push.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and decode.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN forwards the incoming
// instruction straight to decode when the queue is empty.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on the same side; valid never depends on ready on that side, and
// the presented entry is held unchanged while valid is high and ready is low.
// flush (and reset) cancel both transfers in the cycle they are asserted.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = INSTR_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_instr,
    input  logic [WIDTH-1:0]        in_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_instr,
    output logic [WIDTH-1:0]        out_pc,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [WIDTH-1:0] NOP_W   = WIDTH'(NOP_INSTR);

    logic [AW-1:0]      wptr;
    logic [AW-1:0]      rptr;
    logic [CW-1:0]      count_q;
    logic [2*WIDTH-1:0] rdata;
    logic               empty;
    logic               full;
    logic               bypass;
    logic               push_acc;
    logic               pop_acc;
    logic               do_write;
    logic               do_read;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // Full blocks a push even if decode pops the head in the same cycle.
    assign in_ready = !full && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && in_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !empty || bypass;

    // Head entry (or forwarded input) to decode; NOP and pc 0 when idle.
    always_comb begin
        out_instr = NOP_W;
        out_pc    = '0;
        if (!empty) begin
            out_instr = rdata[WIDTH-1:0];
            out_pc    = rdata[2*WIDTH-1:WIDTH];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (bypass) begin
            out_instr = in_instr;
            out_pc    = in_pc;
        end
`endif
    end

    assign push_acc = in_valid && in_ready;
    assign pop_acc  = out_valid && out_ready && !flush;
    // A forwarded entry taken by decode in the same cycle never touches storage.
    assign do_write = push_acc && !(bypass && out_ready) && !reset;
    assign do_read  = pop_acc && !empty;

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_write) begin
                wptr <= wptr + 1'b1;
            end
            if (do_read) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign count = count_q;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock (clock),
        .we    (do_write),
        .waddr (wptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rptr),
        .rdata (rdata)
    );

endmodule
